// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU operand stage: operand-source codes, ALU op codes
// and the skid-buffer occupancy encoding.
package alu_operand_stage_pkg;

    localparam logic OPD1_SRC_RS1 = 1'b0;
    localparam logic OPD1_SRC_PC  = 1'b1;
    localparam logic OPD2_SRC_RS2 = 1'b0;
    localparam logic OPD2_SRC_IMM = 1'b1;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b1000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// Per-source operand forwarding: EX/MEM beats MEM/WB beats register file, index 0 never forwarded.
// Priority logic exists only when ALU_OPERAND_FWD_EN is defined; otherwise register data passes through.
module operand_forward_mux #(
    parameter int OPERAND_LENGTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [OPERAND_LENGTH-1:0] reg_data,
    input  logic                      exmem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [OPERAND_LENGTH-1:0] exmem_data,
    input  logic                      memwb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [OPERAND_LENGTH-1:0] memwb_data,
    output logic [OPERAND_LENGTH-1:0] fwd_data
);

`ifdef ALU_OPERAND_FWD_EN
    logic src_nonzero;

    assign src_nonzero = (src_addr != '0);

    always_comb begin
        fwd_data = reg_data;
        if (src_nonzero && exmem_valid && (exmem_rd == src_addr)) begin
            fwd_data = exmem_data;
        end else if (src_nonzero && memwb_valid && (memwb_rd == src_addr)) begin
            fwd_data = memwb_data;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{src_addr, exmem_valid, exmem_rd, exmem_data,
                          memwb_valid, memwb_rd, memwb_data};
    assign fwd_data   = reg_data;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage feeding the ALU adder: forwarding, operand select and a 2-entry skid buffer.
// Forwarding is compiled in only when ALU_OPERAND_FWD_EN is defined.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int OPERAND_LENGTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPERAND_LENGTH-1:0] rs1_data,
    input  logic [OPERAND_LENGTH-1:0] rs2_data,
    input  logic [OPERAND_LENGTH-1:0] pc,
    input  logic [OPERAND_LENGTH-1:0] imm,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                      opd1_src,
    input  logic                      opd2_src,
    input  logic [3:0]                alu_op_select_in,
    input  logic                      fwd_exmem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_exmem_rd,
    input  logic [OPERAND_LENGTH-1:0] fwd_exmem_data,
    input  logic                      fwd_memwb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_memwb_rd,
    input  logic [OPERAND_LENGTH-1:0] fwd_memwb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] opd1,
    output logic [OPERAND_LENGTH-1:0] opd2,
    output logic [3:0]                alu_op_select,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr
);

    logic [OPERAND_LENGTH-1:0] rs1_fwd;
    logic [OPERAND_LENGTH-1:0] rs2_fwd;
    logic [OPERAND_LENGTH-1:0] new_opd1;
    logic [OPERAND_LENGTH-1:0] new_opd2;

    logic [OPERAND_LENGTH-1:0] skid_opd1;
    logic [OPERAND_LENGTH-1:0] skid_opd2;
    logic [3:0]                skid_op;
    logic [REG_ADDR_WIDTH-1:0] skid_rd;

    occ_state_t state;
    occ_state_t state_next;
    logic       accept;
    logic       consume;

    operand_forward_mux #(
        .OPERAND_LENGTH(OPERAND_LENGTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rs1_fwd (
        .src_addr   (rs1_addr),
        .reg_data   (rs1_data),
        .exmem_valid(fwd_exmem_valid),
        .exmem_rd   (fwd_exmem_rd),
        .exmem_data (fwd_exmem_data),
        .memwb_valid(fwd_memwb_valid),
        .memwb_rd   (fwd_memwb_rd),
        .memwb_data (fwd_memwb_data),
        .fwd_data   (rs1_fwd)
    );

    operand_forward_mux #(
        .OPERAND_LENGTH(OPERAND_LENGTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_rs2_fwd (
        .src_addr   (rs2_addr),
        .reg_data   (rs2_data),
        .exmem_valid(fwd_exmem_valid),
        .exmem_rd   (fwd_exmem_rd),
        .exmem_data (fwd_exmem_data),
        .memwb_valid(fwd_memwb_valid),
        .memwb_rd   (fwd_memwb_rd),
        .memwb_data (fwd_memwb_data),
        .fwd_data   (rs2_fwd)
    );

    assign new_opd1 = (opd1_src == OPD1_SRC_PC)  ? pc  : rs1_fwd;
    assign new_opd2 = (opd2_src == OPD2_SRC_IMM) ? imm : rs2_fwd;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: if (accept) state_next = OCC_ONE;
            OCC_ONE: begin
                if (accept && !consume)      state_next = OCC_FULL;
                else if (consume && !accept) state_next = OCC_EMPTY;
            end
            OCC_FULL:  if (consume) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
        endcase
    end

    // Output entry always holds the oldest instruction; the skid entry only fills
    // when a new one arrives while the output entry is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= OCC_EMPTY;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            opd1          <= '0;
            opd2          <= '0;
            alu_op_select <= '0;
            rd_addr       <= '0;
            skid_opd1     <= '0;
            skid_opd2     <= '0;
            skid_op       <= '0;
            skid_rd       <= '0;
        end else if (flush) begin
            state         <= OCC_EMPTY;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            opd1          <= '0;
            opd2          <= '0;
            alu_op_select <= '0;
            rd_addr       <= '0;
            skid_opd1     <= '0;
            skid_opd2     <= '0;
            skid_op       <= '0;
            skid_rd       <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != OCC_FULL);
            out_valid <= (state_next != OCC_EMPTY);
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        opd1          <= new_opd1;
                        opd2          <= new_opd2;
                        alu_op_select <= alu_op_select_in;
                        rd_addr       <= rd_addr_in;
                    end
                end
                OCC_ONE: begin
                    if (accept && consume) begin
                        opd1          <= new_opd1;
                        opd2          <= new_opd2;
                        alu_op_select <= alu_op_select_in;
                        rd_addr       <= rd_addr_in;
                    end else if (accept) begin
                        skid_opd1 <= new_opd1;
                        skid_opd2 <= new_opd2;
                        skid_op   <= alu_op_select_in;
                        skid_rd   <= rd_addr_in;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        opd1          <= skid_opd1;
                        opd2          <= skid_opd2;
                        alu_op_select <= skid_op;
                        rd_addr       <= skid_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage; expected entries are queued on acceptance
// and compared on consumption. Honours ALU_OPERAND_FWD_EN in its reference model.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int OL = 32;
    localparam int AW = 5;
    localparam int EW = OL + OL + 4 + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [OL-1:0] rs1_data, rs2_data, pc, imm;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr_in;
    logic          opd1_src, opd2_src;
    logic [3:0]    alu_op_select_in;
    logic          fwd_exmem_valid, fwd_memwb_valid;
    logic [AW-1:0] fwd_exmem_rd, fwd_memwb_rd;
    logic [OL-1:0] fwd_exmem_data, fwd_memwb_data;
    logic          out_valid;
    logic          out_ready;
    logic [OL-1:0] opd1, opd2;
    logic [3:0]    alu_op_select;
    logic [AW-1:0] rd_addr;

    typedef struct {
        logic [OL-1:0] rs1d, rs2d, pcv, immv;
        logic [AW-1:0] a1, a2, rd;
        logic          s1, s2;
        logic [3:0]    op;
        logic          exv, mwv;
        logic [AW-1:0] exrd, mwrd;
        logic [OL-1:0] exd, mwd;
    } stim_t;

    logic [EW-1:0] sb[$];
    int            check_count = 0;
    int            pass_count  = 0;
    logic          random_ready = 1'b0;

    alu_operand_stage #(.OPERAND_LENGTH(OL), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr_in(rd_addr_in),
        .opd1_src(opd1_src), .opd2_src(opd2_src), .alu_op_select_in(alu_op_select_in),
        .fwd_exmem_valid(fwd_exmem_valid), .fwd_exmem_rd(fwd_exmem_rd), .fwd_exmem_data(fwd_exmem_data),
        .fwd_memwb_valid(fwd_memwb_valid), .fwd_memwb_rd(fwd_memwb_rd), .fwd_memwb_data(fwd_memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opd1(opd1), .opd2(opd2), .alu_op_select(alu_op_select), .rd_addr(rd_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [EW-1:0] actual, input logic [EW-1:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    function automatic logic [OL-1:0] resolveOperand(input logic [AW-1:0] addr, input logic [OL-1:0] regData);
`ifdef ALU_OPERAND_FWD_EN
        if (addr != 0 && fwd_exmem_valid && fwd_exmem_rd == addr) return fwd_exmem_data;
        if (addr != 0 && fwd_memwb_valid && fwd_memwb_rd == addr) return fwd_memwb_data;
`endif
        return regData;
    endfunction

    function automatic logic [EW-1:0] expectedEntry();
        logic [OL-1:0] e1, e2;
        e1 = opd1_src ? pc  : resolveOperand(rs1_addr, rs1_data);
        e2 = opd2_src ? imm : resolveOperand(rs2_addr, rs2_data);
        return {e1, e2, alu_op_select_in, rd_addr_in};
    endfunction

    function automatic stim_t mkStim(input logic [OL-1:0] rs1d, input logic [OL-1:0] rs2d,
                                     input logic s1, input logic s2, input logic [3:0] op,
                                     input logic [AW-1:0] rd);
        stim_t s;
        s.rs1d = rs1d; s.rs2d = rs2d; s.pcv = 32'h100; s.immv = 32'hFFFF_FFFE;
        s.a1 = 0; s.a2 = 0; s.rd = rd; s.s1 = s1; s.s2 = s2; s.op = op;
        s.exv = 0; s.mwv = 0; s.exrd = 0; s.mwrd = 0; s.exd = 0; s.mwd = 0;
        return s;
    endfunction

    // Pops on each consumption and pushes on each acceptance, both decided at the negedge.
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checkOutput("sb_nonempty", EW'(sb.size() != 0), EW'(1));
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    checkOutput("out_entry", {opd1, opd2, alu_op_select, rd_addr}, exp);
                end
            end
            if (in_valid && in_ready) sb.push_back(expectedEntry());
        end
    end

    task automatic driveInputs(input stim_t s);
        rs1_data = s.rs1d; rs2_data = s.rs2d; pc = s.pcv; imm = s.immv;
        rs1_addr = s.a1; rs2_addr = s.a2; rd_addr_in = s.rd;
        opd1_src = s.s1; opd2_src = s.s2; alu_op_select_in = s.op;
        fwd_exmem_valid = s.exv; fwd_exmem_rd = s.exrd; fwd_exmem_data = s.exd;
        fwd_memwb_valid = s.mwv; fwd_memwb_rd = s.mwrd; fwd_memwb_data = s.mwd;
        in_valid = 1'b1;
    endtask

    task automatic applyStimulus(input stim_t s);
        logic accepted;
        driveInputs(s);
        flush = 1'b0;
        accepted = 1'b0;
        for (int n = 0; n < 64 && !accepted; n++) begin
            if (random_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", EW'(accepted), EW'(1));
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        stim_t s, a, b, c;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        driveInputs(mkStim(0, 0, 0, 0, ALU_OP_ADD, 0));
        in_valid = 1'b0;
        #12;
        checkOutput("reset_out_valid", EW'(out_valid), EW'(0));
        checkOutput("reset_in_ready", EW'(in_ready), EW'(1));
        checkOutput("reset_outputs", {opd1, opd2, alu_op_select, rd_addr}, EW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(mkStim(32'd1, 32'd5, OPD1_SRC_RS1, OPD2_SRC_RS2, ALU_OP_ADD, 5'd7));
        in_valid = 1'b0;
        checkOutput("basic_latency_valid", EW'(out_valid), EW'(1));
        checkOutput("basic_opd", {opd1, opd2}, EW'({32'd1, 32'd5}));
        idleCycles(2);

        applyStimulus(mkStim(32'd11, 32'd22, OPD1_SRC_PC, OPD2_SRC_IMM, ALU_OP_SUB, 5'd2));
        in_valid = 1'b0;
        checkOutput("select_opd", {opd1, opd2}, EW'({32'h100, 32'hFFFF_FFFE}));
        idleCycles(2);

        s = mkStim(32'd0, 32'd4, 0, 0, ALU_OP_ADD, 5'd1);
        s.a1 = 3; s.exv = 1; s.exrd = 3; s.exd = 6; s.mwv = 1; s.mwrd = 3; s.mwd = 9;
        applyStimulus(s);
        s.exv = 0;
        applyStimulus(s);
        s.a1 = 0; s.rs1d = 32'h55; s.exv = 1; s.exrd = 0; s.mwrd = 0;
        applyStimulus(s);
        s = mkStim(32'd8, 32'd0, 0, 0, ALU_OP_SUB, 5'd4);
        s.a2 = 9; s.exv = 1; s.exrd = 8; s.exd = 1; s.mwv = 1; s.mwrd = 9; s.mwd = 32'hABCD;
        applyStimulus(s);
        idleCycles(3);

        // Backpressure: A held, B skidded, C stalled until the ALU drains.
        out_ready = 1'b0;
        a = mkStim(32'hA, 32'hA0, 0, 0, ALU_OP_ADD, 5'd10);
        b = mkStim(32'hB, 32'hB0, 0, 0, ALU_OP_SUB, 5'd11);
        c = mkStim(32'hC, 32'hC0, 0, 0, ALU_OP_ADD, 5'd12);
        applyStimulus(a);
        applyStimulus(b);
        driveInputs(c);
        @(negedge clk);
        checkOutput("bp_in_ready_low", EW'(in_ready), EW'(0));
        checkOutput("bp_hold_a", {opd1, rd_addr}, EW'({32'hA, 5'd10}));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp_still_full", EW'({out_valid, in_ready}), EW'(2'b10));
        checkOutput("bp_stable_a", {opd1, opd2, alu_op_select, rd_addr}, {32'hA, 32'hA0, ALU_OP_ADD, 5'd10});
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(c);
        idleCycles(4);
        checkOutput("bp_drained", EW'(sb.size()), EW'(0));

        // Flush while FULL with a live input: both entries and the input vanish.
        out_ready = 1'b0;
        applyStimulus(mkStim(32'h21, 32'h22, 0, 0, ALU_OP_ADD, 5'd1));
        applyStimulus(mkStim(32'h31, 32'h32, 0, 0, ALU_OP_ADD, 5'd2));
        driveInputs(mkStim(32'hDEAD, 32'hBEEF, 0, 0, ALU_OP_SUB, 5'd3));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_state", EW'({out_valid, in_ready}), EW'(2'b01));
        out_ready = 1'b1;
        idleCycles(4);
        checkOutput("flush_no_output", EW'(out_valid), EW'(0));

        // Asynchronous reset in the middle of a cycle while FULL.
        out_ready = 1'b0;
        applyStimulus(mkStim(32'h41, 32'h42, 0, 0, ALU_OP_SUB, 5'd5));
        applyStimulus(mkStim(32'h51, 32'h52, 0, 0, ALU_OP_ADD, 5'd6));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("areset_outputs", {opd1, opd2, alu_op_select, rd_addr}, EW'(0));
        checkOutput("areset_handshake", EW'({out_valid, in_ready}), EW'(2'b01));
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_empty", EW'(out_valid), EW'(0));

        random_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s.rs1d = $urandom; s.rs2d = $urandom; s.pcv = $urandom; s.immv = $urandom;
            s.a1 = AW'($urandom_range(0, 3)); s.a2 = AW'($urandom_range(0, 3));
            s.rd = AW'($urandom_range(0, 31));
            s.s1 = 1'($urandom_range(0, 1)); s.s2 = 1'($urandom_range(0, 1));
            s.op = 4'($urandom_range(0, 15));
            s.exv = 1'($urandom_range(0, 1)); s.exrd = AW'($urandom_range(0, 3)); s.exd = $urandom;
            s.mwv = 1'($urandom_range(0, 1)); s.mwrd = AW'($urandom_range(0, 3)); s.mwd = $urandom;
            applyStimulus(s);
        end
        random_ready = 1'b0;
        out_ready = 1'b1;
        idleCycles(6);
        checkOutput("random_drained", EW'(sb.size()), EW'(0));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU adder.
- Accepts decoded instructions from the decode stage and selects opd1 (rs1 or pc) and opd2 (rs2 or imm).
- Resolves EX/MEM and MEM/WB operand forwarding, then buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Outputs drive the adder's opd1, opd2 and alu_op_select directly.

Parameters:
- OPERAND_LENGTH, 32, data width of all operands, pc and imm.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- rs1_data, rs2_data  in  OPERAND_LENGTH  register file read data.
- pc, imm  in  OPERAND_LENGTH  instruction pc and sign-extended immediate.
- rs1_addr, rs2_addr, rd_addr_in  in  REG_ADDR_WIDTH  source and destination indices.
- opd1_src  in  1  0 = rs1, 1 = pc.
- opd2_src  in  1  0 = rs2, 1 = imm.
- alu_op_select_in  in  4  ALU operation; bit 3 set = subtract.
- fwd_exmem_valid  in  1  EX/MEM result writes back.
- fwd_exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination.
- fwd_exmem_data  in  OPERAND_LENGTH  EX/MEM result.
- fwd_memwb_valid, fwd_memwb_rd, fwd_memwb_data  in  1/REG_ADDR_WIDTH/OPERAND_LENGTH  MEM/WB equivalents.
- out_valid  out  1  opd1/opd2 valid to ALU.
- out_ready  in  1  ALU consumes this cycle.
- opd1, opd2  out  OPERAND_LENGTH  ALU operands.
- alu_op_select  out  4  ALU operation.
- rd_addr  out  REG_ADDR_WIDTH  destination index.

Behaviour:
- Reset: all outputs 0, except in_ready = 1. State = EMPTY. Reset is asynchronous and effective mid-transfer, with no partial state retained.
- Occupancy states: EMPTY, ONE, FULL.
  - accept = in_valid & in_ready; consume = out_valid & out_ready.
  - EMPTY: accept → ONE.
  - ONE: accept & ~consume → FULL; consume & ~accept → EMPTY; both or neither → ONE.
  - FULL: in_ready = 0; consume → ONE, with the skid entry promoted to the output entry.
- in_ready is 1 in EMPTY and ONE, and is registered (no combinational path from out_ready).
- out_valid = state != EMPTY. The outputs always show the oldest entry and stay stable while out_valid & ~out_ready.
- Latency: an accepted instruction appears at the outputs the next cycle when the buffer was EMPTY. Throughput is 1 per cycle while out_ready = 1.
- Forwarding is resolved combinationally at acceptance, per source. Priority order:
  1. EX/MEM match (valid, rd == addr, addr != 0).
  2. MEM/WB match.
  3. Register file data.
- Index 0 is never forwarded. An entry held in the skid is not re-forwarded; the hazard unit stalls in_valid as needed.
- Operand select is applied after forwarding: opd1 = opd1_src ? pc : rs1_fwd; opd2 = opd2_src ? imm : rs2_fwd. No width change, pure selection.
- flush: next edge clears both entries, giving state EMPTY, out_valid = 0, in_ready = 1. An input presented in the flush cycle is dropped. Flush has priority over accept and consume.

Optional Feature:
- Macro ALU_OPERAND_FWD_EN.
- Defined: forwarding logic as above.
- Undefined: fwd_* ports remain but are ignored; rs1_fwd = rs1_data and rs2_fwd = rs2_data; no forwarding mux is synthesized.

Decomposition:
- Shared header/package holds:
  - OPD1_SRC_RS1 = 0, OPD1_SRC_PC = 1.
  - OPD2_SRC_RS2 = 0, OPD2_SRC_IMM = 1.
  - ALU_OP_ADD = 4'b0000, ALU_OP_SUB = 4'b1000.
  - Occupancy state encodings.
- Sub-module operand_forward_mux: one instance per source (rs1, rs2). It holds the priority match logic and is wrapped by ALU_OPERAND_FWD_EN.

Test Plan:
- Basic: reset, then accept rs1_data = 1, rs2_data = 5, srcs = 0, op = 0000 with out_ready = 1 → next cycle out_valid = 1, opd1 = 1, opd2 = 5, alu_op_select = 0000.
- Selection: pc = 0x100, imm = 0xFFFFFFFE, opd1_src = 1, opd2_src = 1 → opd1 = 0x100, opd2 = 0xFFFFFFFE.
- Forwarding priority: rs1_addr = 3, exmem rd = 3 data = 6, memwb rd = 3 data = 9, rs1_data = 0 → opd1 = 6. With exmem_valid = 0 → opd1 = 9. With rs1_addr = 0 and both matching 0 → opd1 = rs1_data.
- Backpressure: out_ready = 0 and three back-to-back valids A, B, C → A held at the outputs, B accepted, in_ready = 0 from the cycle after B, C held. Then out_ready = 1 → A, B, C delivered in order, none lost or duplicated.
- Flush in FULL with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the dropped input never appears.
- Async reset asserted mid-cycle while FULL → outputs zero immediately without waiting for a clock edge; in_ready = 1.
